// File: rtl/router_pkg.sv
// Shared definitions for the router packet interface: widths, state encoding
// and the header/parity helpers used by both the transmit and receive sides.
package router_pkg;

  localparam int DATA_W = 8;
  localparam int LEN_W  = 6;
  localparam logic [1:0] ADDR_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FILL    = 3'd1,
    HEADER  = 3'd2,
    PAYLOAD = 3'd3,
    PARITY  = 3'd4,
    GAP     = 3'd5
  } tx_state_e;

  function automatic logic [DATA_W-1:0] hdr_pack(input logic [LEN_W-1:0] len,
                                                 input logic [1:0]       addr);
    return {len, addr};
  endfunction

  function automatic logic [LEN_W-1:0] hdr_len(input logic [DATA_W-1:0] hdr);
    return hdr[DATA_W-1:2];
  endfunction

  function automatic logic [1:0] hdr_addr(input logic [DATA_W-1:0] hdr);
    return hdr[1:0];
  endfunction

  function automatic logic [DATA_W-1:0] parity_fold(input logic [DATA_W-1:0] acc,
                                                    input logic [DATA_W-1:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload FIFO for the packet transmitter. Besides pop it can discard a whole
// run of entries at once, used to throw away the rest of an aborted packet.
module router_tx_buf
  import router_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              flush,
  input  logic [LEN_W:0]    flush_n,
  output logic [DATA_W-1:0] head_data,
  output logic [DATA_W-1:0] next_data,
  output logic [LEN_W:0]    count,
  output logic              full
);

  localparam int DEPTH = 2**LEN_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [LEN_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LEN_W:0]    count_q, count_d, adv_s;
  logic              do_push_s;

  // count never exceeds DEPTH, so the top bit alone means full
  assign full      = count_q[LEN_W];
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];
  assign next_data = mem_q[rd_ptr_q + LEN_W'(1)];

  // pointer and occupancy update
  always_comb begin
    do_push_s = push && !full;
    if (pop) begin
      adv_s = (LEN_W+1)'(1);
    end else if (flush) begin
      adv_s = flush_n;
    end else begin
      adv_s = {(LEN_W+1){1'b0}};
    end
    rd_ptr_d = rd_ptr_q + adv_s[LEN_W-1:0];
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + LEN_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    count_d = count_q - adv_s + {{LEN_W{1'b0}}, do_push_s};
  end

  // pointer/count registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= {LEN_W{1'b0}};
      rd_ptr_q <= {LEN_W{1'b0}};
      count_q  <= {(LEN_W+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // storage array; contents are don't-care until written
  always_ff @(posedge clock) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/router_pkt_tx.sv
// Packet source for the router input port: buffers a payload, then sends
// header, payload and parity, stalling on busy and aborting on a stuck busy.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter logic [15:0] BUSY_TIMEOUT = 16'hFFFF,
  parameter int unsigned GAP_CYCLES   = 32'd1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_corrupt,
  input  logic              pld_valid,
  output logic              pld_ready,
  input  logic [DATA_W-1:0] pld_data,
  input  logic              busy,
  output logic              pkt_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              tx_done,
  output logic              tx_err
);

  tx_state_e         state_q, state_d;
  logic [1:0]        addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              corrupt_q, corrupt_d;
  logic [DATA_W-1:0] parity_q, parity_d;
  logic [LEN_W:0]    byte_cnt_q, byte_cnt_d;
  logic [15:0]       busy_cnt_q, busy_cnt_d;
  logic [15:0]       gap_cnt_q, gap_cnt_d;
  logic              pkt_valid_q, pkt_valid_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              tx_done_q, tx_done_d;
  logic              tx_err_q, tx_err_d;

  logic              buf_pop_s, buf_flush_s, buf_full_s, in_pkt_s;
  logic [LEN_W:0]    buf_flush_n_s, buf_count_s;
  logic [DATA_W-1:0] buf_head_s, buf_next_s;

  router_tx_buf u_buf (
    .clock     (clock),
    .resetn    (resetn),
    .push      (pld_valid && pld_ready),
    .push_data (pld_data),
    .pop       (buf_pop_s),
    .flush     (buf_flush_s),
    .flush_n   (buf_flush_n_s),
    .head_data (buf_head_s),
    .next_data (buf_next_s),
    .count     (buf_count_s),
    .full      (buf_full_s)
  );

  assign cmd_ready = (state_q == IDLE);
  assign pld_ready = !buf_full_s;
  assign in_pkt_s  = (state_q == HEADER) || (state_q == PAYLOAD) || (state_q == PARITY);
  assign pkt_valid = pkt_valid_q;
  assign data_out  = data_out_q;
  assign tx_done   = tx_done_q;
  assign tx_err    = tx_err_q;

  // next-state and next-output logic; outputs are staged for the state being entered
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    len_d         = len_q;
    corrupt_d     = corrupt_q;
    parity_d      = parity_q;
    byte_cnt_d    = byte_cnt_q;
    busy_cnt_d    = busy_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    pkt_valid_d   = pkt_valid_q;
    data_out_d    = data_out_q;
    tx_done_d     = 1'b0;
    tx_err_d      = 1'b0;
    buf_pop_s     = 1'b0;
    buf_flush_s   = 1'b0;
    buf_flush_n_s = {(LEN_W+1){1'b0}};
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_addr == ADDR_ILLEGAL || cmd_len == {LEN_W{1'b0}}) begin
            tx_err_d = 1'b1;
          end else begin
            addr_d    = cmd_addr;
            len_d     = cmd_len;
            corrupt_d = cmd_corrupt;
            state_d   = FILL;
          end
        end else begin
          state_d = IDLE;
        end
      end
      FILL: begin
        if ({1'b0, len_q} <= buf_count_s) begin
          state_d     = HEADER;
          pkt_valid_d = 1'b1;
          data_out_d  = hdr_pack(len_q, addr_q);
          byte_cnt_d  = {(LEN_W+1){1'b0}};
        end else begin
          state_d = FILL;
        end
      end
      HEADER: begin
        if (!busy) begin
          parity_d   = data_out_q;
          data_out_d = buf_head_s;
          state_d    = PAYLOAD;
        end else begin
          state_d = HEADER;
        end
      end
      PAYLOAD: begin
        if (!busy) begin
          buf_pop_s  = 1'b1;
          parity_d   = parity_fold(parity_q, data_out_q);
          byte_cnt_d = byte_cnt_q + (LEN_W+1)'(1);
          // head has just been popped, so the following byte comes from next_data
          if (byte_cnt_q + (LEN_W+1)'(1) == {1'b0, len_q}) begin
            state_d     = PARITY;
            pkt_valid_d = 1'b0;
            data_out_d  = parity_fold(parity_q, data_out_q) ^ {{(DATA_W-1){1'b0}}, corrupt_q};
          end else begin
            data_out_d = buf_next_s;
          end
        end else begin
          state_d = PAYLOAD;
        end
      end
      PARITY: begin
        if (!busy) begin
          tx_done_d  = 1'b1;
          data_out_d = {DATA_W{1'b0}};
          gap_cnt_d  = 16'd0;
          state_d    = GAP;
        end else begin
          state_d = PARITY;
        end
      end
      GAP: begin
        if (gap_cnt_q == 16'(GAP_CYCLES - 32'd1)) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 16'd1;
        end
      end
      default: begin
        state_d     = IDLE;
        pkt_valid_d = 1'b0;
        data_out_d  = {DATA_W{1'b0}};
      end
    endcase
    // stall watchdog: a stuck busy drops the unsent remainder of this packet
    if (in_pkt_s) begin
      if (!busy) begin
        busy_cnt_d = 16'd0;
      end else if (busy_cnt_q + 16'd1 == BUSY_TIMEOUT) begin
        tx_err_d      = 1'b1;
        pkt_valid_d   = 1'b0;
        data_out_d    = {DATA_W{1'b0}};
        buf_flush_s   = 1'b1;
        buf_flush_n_s = {1'b0, len_q} - byte_cnt_q;
        busy_cnt_d    = 16'd0;
        gap_cnt_d     = 16'd0;
        state_d       = GAP;
      end else begin
        busy_cnt_d = busy_cnt_q + 16'd1;
      end
    end else begin
      busy_cnt_d = 16'd0;
    end
  end

  // state and output registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      addr_q      <= 2'd0;
      len_q       <= {LEN_W{1'b0}};
      corrupt_q   <= 1'b0;
      parity_q    <= {DATA_W{1'b0}};
      byte_cnt_q  <= {(LEN_W+1){1'b0}};
      busy_cnt_q  <= 16'd0;
      gap_cnt_q   <= 16'd0;
      pkt_valid_q <= 1'b0;
      data_out_q  <= {DATA_W{1'b0}};
      tx_done_q   <= 1'b0;
      tx_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      corrupt_q   <= corrupt_d;
      parity_q    <= parity_d;
      byte_cnt_q  <= byte_cnt_d;
      busy_cnt_q  <= busy_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      pkt_valid_q <= pkt_valid_d;
      data_out_q  <= data_out_d;
      tx_done_q   <= tx_done_d;
      tx_err_q    <= tx_err_d;
    end
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Bench for router_pkt_tx: directed packets with literal expectations, then
// random traffic compared every cycle against a packet-level model.
module tb_router_pkt_tx;
  import router_pkg::*;

  localparam int TMO = 8;
  localparam int P_IDLE = 0, P_WAIT = 1, P_SEND = 2, P_GAP = 3;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_corrupt = 1'b0;
  logic [1:0]  cmd_addr = 2'd0;
  logic [5:0]  cmd_len = 6'd0;
  logic        pld_valid = 1'b0, busy = 1'b0;
  logic [7:0]  pld_data = 8'd0;
  logic        cmd_ready, pld_ready, pkt_valid, tx_done, tx_err;
  logic [7:0]  data_out;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  router_pkt_tx #(.BUSY_TIMEOUT(16'd8), .GAP_CYCLES(32'd1)) dut (
    .clock(clock), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_corrupt(cmd_corrupt),
    .pld_valid(pld_valid), .pld_ready(pld_ready), .pld_data(pld_data), .busy(busy),
    .pkt_valid(pkt_valid), .data_out(data_out), .tx_done(tx_done), .tx_err(tx_err)
  );

  // packet-level model: payload queue plus the full byte list of the packet in flight
  logic [7:0] m_fifo[$];
  logic [7:0] m_pkt[$];
  int   m_phase = P_IDLE, m_idx = 0, m_len = 0, m_busy_run = 0, m_gap = 0;
  logic [1:0] m_addr = 2'd0;
  logic m_corrupt = 1'b0, m_done = 1'b0, m_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_phase = P_IDLE; m_idx = 0; m_busy_run = 0; m_gap = 0;
    m_done = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_step();
    logic       push_ok;
    logic [7:0] par;
    int         popped;
    push_ok = pld_valid && (m_fifo.size() < 64);
    m_done = 1'b0;
    m_err  = 1'b0;
    case (m_phase)
      P_IDLE: if (cmd_valid) begin
        if (cmd_addr == 2'd3 || cmd_len == 6'd0) m_err = 1'b1;
        else begin
          m_len = int'(cmd_len); m_addr = cmd_addr; m_corrupt = cmd_corrupt;
          m_phase = P_WAIT;
        end
      end
      P_WAIT: if (m_fifo.size() >= m_len) begin
        m_pkt.delete();
        m_pkt.push_back(8'(m_len * 4 + int'(m_addr)));
        par = m_pkt[0];
        for (int i = 0; i < m_len; i++) begin
          m_pkt.push_back(m_fifo[i]);
          par = par ^ m_fifo[i];
        end
        m_pkt.push_back(par ^ {7'd0, m_corrupt});
        m_idx = 0; m_busy_run = 0; m_phase = P_SEND;
      end
      P_SEND: if (busy) begin
        m_busy_run++;
        if (m_busy_run == TMO) begin
          popped = (m_idx == 0) ? 0 : m_idx - 1;
          repeat (m_len - popped) void'(m_fifo.pop_front());
          m_err = 1'b1; m_phase = P_GAP; m_gap = 1;
        end
      end else begin
        m_busy_run = 0;
        if (m_idx >= 1 && m_idx <= m_len) void'(m_fifo.pop_front());
        m_idx++;
        if (m_idx == m_len + 2) begin
          m_done = 1'b1; m_phase = P_GAP; m_gap = 1;
        end
      end
      P_GAP: begin
        m_gap--;
        if (m_gap == 0) m_phase = P_IDLE;
      end
      default: m_phase = P_IDLE;
    endcase
    if (push_ok) m_fifo.push_back(pld_data);
  endtask

  initial begin
    forever begin
      @(posedge clock or negedge resetn);
      if (!resetn) model_reset();
      else model_step();
    end
  end

  // per-cycle comparison against the model
  initial begin
    logic       exp_pv;
    logic [7:0] exp_d;
    forever begin
      @(negedge clock);
      exp_pv = (m_phase == P_SEND) && (m_idx <= m_len);
      exp_d  = (m_phase == P_SEND) ? m_pkt[m_idx] : 8'd0;
      chk("m_pkt_valid", 32'(pkt_valid), 32'(exp_pv));
      chk("m_data_out",  32'(data_out),  32'(exp_d));
      chk("m_cmd_ready", 32'(cmd_ready), 32'(m_phase == P_IDLE));
      chk("m_pld_ready", 32'(pld_ready), 32'(m_fifo.size() < 64));
      chk("m_tx_done",   32'(tx_done),   32'(m_done));
      chk("m_tx_err",    32'(tx_err),    32'(m_err));
    end
  end

  task automatic push_bytes(input logic [7:0] b[$]);
    for (int i = 0; i < b.size(); i++) begin
      pld_valid = 1'b1; pld_data = b[i];
      @(negedge clock);
    end
    pld_valid = 1'b0;
  endtask

  task automatic issue_cmd(input logic [1:0] a, input logic [5:0] l, input logic c);
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = l; cmd_corrupt = c;
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  // header shows on the second edge after accept; optional busy stall at one byte
  task automatic expect_pkt(input logic [7:0] e[$], input int stall_idx, input int stall_n);
    @(negedge clock);
    for (int i = 0; i < e.size(); i++) begin
      chk("d_byte", 32'(data_out), 32'(e[i]));
      chk("d_pkt_valid", 32'(pkt_valid), 32'(i < e.size() - 1));
      if (i == stall_idx) begin
        busy = 1'b1;
        for (int s = 0; s < stall_n; s++) begin
          @(negedge clock);
          chk("d_hold", 32'(data_out), 32'(e[i]));
        end
        busy = 1'b0;
      end
      @(negedge clock);
    end
    chk("d_tx_done", 32'(tx_done), 32'd1);
    chk("d_gap_data", 32'(data_out), 32'd0);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] e[$];
    int burst;
    repeat (2) @(negedge clock);
    chk("rst_pkt_valid", 32'(pkt_valid), 32'd0);
    chk("rst_data_out",  32'(data_out),  32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_pld_ready", 32'(pld_ready), 32'd1);
    chk("rst_tx_done",   32'(tx_done),   32'd0);
    chk("rst_tx_err",    32'(tx_err),    32'd0);
    resetn = 1'b1;
    @(negedge clock);

    q = '{8'h11, 8'h22, 8'h33};
    e = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
    push_bytes(q); issue_cmd(2'd1, 6'd3, 1'b0); expect_pkt(e, -1, 0);
    chk("model_hdr", 32'(m_pkt[0]), 32'h0D);
    chk("model_parity", 32'(m_pkt[4]), 32'h0D);

    push_bytes(q); issue_cmd(2'd1, 6'd3, 1'b0); expect_pkt(e, 2, 3);

    e = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0C};
    push_bytes(q); issue_cmd(2'd1, 6'd3, 1'b1); expect_pkt(e, -1, 0);
    chk("model_corrupt", 32'(m_pkt[4]), 32'h0C);

    @(negedge clock);
    issue_cmd(2'd3, 6'd2, 1'b0);
    chk("ill_addr_err", 32'(tx_err), 32'd1);
    chk("ill_addr_pv", 32'(pkt_valid), 32'd0);
    chk("ill_addr_rdy", 32'(cmd_ready), 32'd1);
    @(negedge clock);
    chk("ill_err_pulse", 32'(tx_err), 32'd0);
    issue_cmd(2'd0, 6'd0, 1'b0);
    chk("ill_len_err", 32'(tx_err), 32'd1);
    chk("ill_len_rdy", 32'(cmd_ready), 32'd1);

    // stuck busy mid-payload; the trailing A1/A2 belong to the next packet
    q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hA1, 8'hA2};
    push_bytes(q); issue_cmd(2'd2, 6'd4, 1'b0);
    @(negedge clock);
    chk("tmo_hdr", 32'(data_out), 32'h12);
    @(negedge clock);
    chk("tmo_first", 32'(data_out), 32'h01);
    busy = 1'b1;
    repeat (TMO - 1) begin
      @(negedge clock);
      chk("tmo_wait_err", 32'(tx_err), 32'd0);
      chk("tmo_wait_hold", 32'(data_out), 32'h01);
    end
    @(negedge clock);
    chk("tmo_err", 32'(tx_err), 32'd1);
    chk("tmo_pv", 32'(pkt_valid), 32'd0);
    chk("tmo_data", 32'(data_out), 32'd0);
    busy = 1'b0;
    @(negedge clock);
    e = '{8'h08, 8'hA1, 8'hA2, 8'h0B};
    issue_cmd(2'd0, 6'd2, 1'b0); expect_pkt(e, -1, 0);

    q = '{8'h55, 8'h66, 8'h77};
    push_bytes(q); issue_cmd(2'd1, 6'd3, 1'b0);
    repeat (3) @(negedge clock);
    resetn = 1'b0;
    #1;
    chk("midrst_pv", 32'(pkt_valid), 32'd0);
    chk("midrst_data", 32'(data_out), 32'd0);
    chk("midrst_rdy", 32'(cmd_ready), 32'd1);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);

    burst = 0;
    for (int c = 0; c < 4000; c++) begin
      pld_data = 8'($urandom);
      if (c >= 1000 && c < 1100) begin
        pld_valid = 1'b1; cmd_valid = 1'b0;
      end else begin
        pld_valid = ($urandom_range(0, 99) < 55);
        cmd_valid = ($urandom_range(0, 7) == 0);
      end
      cmd_addr = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      cmd_len  = ($urandom_range(0, 15) == 0) ? 6'd0 : 6'($urandom_range(1, (c < 2000) ? 12 : 63));
      cmd_corrupt = 1'($urandom_range(0, 1));
      if (burst > 0) begin
        busy = 1'b1; burst--;
      end else if ($urandom_range(0, 99) == 0) begin
        busy = 1'b1; burst = $urandom_range(5, 12);
      end else begin
        busy = ($urandom_range(0, 3) == 0);
      end
      @(negedge clock);
    end
    cmd_valid = 1'b0; pld_valid = 1'b0; busy = 1'b0;
    repeat (20) @(negedge clock);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
